audio_dma: RTL and testbench
============================

Name: audio_dma

Overview:
- Audio sample fetcher. Occupies the audio read port of the memory arbiter: au_memory_address, au_memory_data, au_rvalid, au_rready.
- Loops over a CPU-configured ring buffer of interleaved stereo 16-bit samples (L, R, L, R, ...) in main memory and buffers the pairs in a small FIFO.
- Presents one stereo pair per sample period to the downstream DAC/PWM stage and raises half/end interrupts so the CPU can refill the buffer.

Parameters:
- CLOCK_FREQ, 10000000, system clock frequency in Hz.
- SAMPLE_RATE, 25000, output pair rate in Hz. Divisor DIV = CLOCK_FREQ/SAMPLE_RATE (integer, >= 8).
- FIFO_DEPTH, 4, number of stereo-pair entries in the FIFO. Must be a power of two.

Ports:
- CLK  in  1  system clock
- RSTb  in  1  asynchronous active-low reset
- reg_addr  in  2  register select: 0 = BASE, 1 = LEN, 2 = CTRL
- reg_data  in  16  register write data
- reg_wr  in  1  one-cycle register write strobe
- au_memory_address  out  16  word address to the arbiter
- au_memory_data  in  16  read data from the arbiter
- au_rvalid  out  1  request valid
- au_rready  in  1  data valid / request accepted
- au_left  out  16  current left sample
- au_right  out  16  current right sample
- au_strobe  out  1  one-cycle pulse when au_left/au_right update
- half_irq  out  1  one-cycle pulse: first half of the buffer consumed by the fetcher
- end_irq  out  1  one-cycle pulse: fetcher wrapped at the end of the buffer
- underrun  out  1  sticky: a sample tick found the FIFO empty

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; offset 0; divider 0. Reset is asynchronous and may arrive mid-request; au_rvalid drops immediately.
- Registers:
  - BASE: 16-bit word address of the buffer.
  - LEN: length in words. Bit 0 is ignored (forced even); a value < 4 is treated as 4.
  - CTRL bit0 = enable. Any CTRL write clears underrun.
  - BASE and LEN writes take effect at the next enable rising edge.
- Handshake:
  - Address is held stable with au_rvalid high until au_rready is seen.
  - Data is captured in the au_rready cycle.
  - au_rvalid deasserts in the cycle after au_rready, so requests are never back-to-back. Minimum 2 cycles per word.
- Fetch FSM:
  - IDLE -> REQ_L when enabled and FIFO count < FIFO_DEPTH.
  - REQ_L: address = BASE + offset; on au_rready, latch L, offset += 1, go to GAP_L.
  - GAP_L -> REQ_R (one cycle, au_rvalid low).
  - REQ_R: same as REQ_L, then PUSH.
  - PUSH: write {L, R} into the FIFO, return to IDLE.
  - Address arithmetic is 16 bits and wraps modulo 2^16.
  - Offset wraps to 0 when it reaches LEN. end_irq pulses in the accept cycle of word LEN-1. half_irq pulses in the accept cycle of word LEN/2-1.
- Playback:
  - The divider counts 0..DIV-1 while enabled; a tick occurs at DIV-1.
  - Tick with FIFO non-empty: pop one pair, register it onto au_left/au_right, pulse au_strobe on the next cycle.
  - Tick with FIFO empty: hold au_left/au_right, no strobe, set underrun.
- A PUSH and a pop in the same cycle are both honoured; count is unchanged.
- Disable (CTRL bit0 = 0):
  - If in REQ_L/REQ_R, hold au_rvalid until au_rready, discard the data, go to IDLE. No IRQs fire for the discarded word.
  - The FIFO is flushed once the FSM reaches IDLE.
  - Divider resets to 0; outputs hold their last values.
- Re-enable restarts from offset 0 using the current BASE/LEN.
- First strobe after enable occurs at the first tick after the FIFO becomes non-empty. With an always-ready arbiter the FIFO fills long before the first tick.

Test Plan:
- BASE=0x4000, LEN=8, enable, arbiter returns data = address, au_rready one cycle after au_rvalid:
  - Address sequence 0x4000..0x4007 then 0x4000.
  - half_irq on the accept of 0x4003; end_irq on the accept of 0x4007.
- Same setup, DIV=400:
  - First au_strobe ~400 cycles after enable with au_left=0x4000, au_right=0x4001.
  - Next strobe exactly 400 cycles later with 0x4002/0x4003.
- Arbiter stalls au_rready for 2000 cycles after the FIFO drains:
  - underrun goes to 1; au_left/au_right hold their previous values; no strobe.
  - A CTRL write of 1 clears underrun.
- Disable while REQ_R is pending with au_rready delayed 5 cycles:
  - au_rvalid stays high until au_rready, then drops.
  - FIFO empty; no IRQ.
  - Re-enable: first address is BASE+0.
- LEN=5 written:
  - Behaves as LEN=4; addresses BASE..BASE+3 repeat.
  - half_irq at word 1, end_irq at word 3.
- BASE=0xFFFE, LEN=4: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, then 0xFFFE.
- Assert RSTb low during REQ_L:
  - All outputs 0 immediately.
  - After release, no request until enable is written.

Source files
------------

// File: rtl/audio_dma.sv
// audio_dma: fetches interleaved stereo samples from a memory ring buffer
// and replays them at the sample rate through a small pair FIFO.
module audio_dma #(
  parameter int CLOCK_FREQ  = 10000000,
  parameter int SAMPLE_RATE = 25000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic [1:0]  reg_addr,
  input  logic [15:0] reg_data,
  input  logic        reg_wr,
  output logic [15:0] au_memory_address,
  input  logic [15:0] au_memory_data,
  output logic        au_rvalid,
  input  logic        au_rready,
  output logic [15:0] au_left,
  output logic [15:0] au_right,
  output logic        au_strobe,
  output logic        half_irq,
  output logic        end_irq,
  output logic        underrun
);

  localparam int DIV = CLOCK_FREQ / SAMPLE_RATE;
  localparam int DW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ_L = 3'd1;
  localparam logic [2:0] S_GAP_L = 3'd2;
  localparam logic [2:0] S_REQ_R = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;

  logic [15:0] base_q, len_q, cur_base_q, cur_len_q;
  logic        en_q;
  logic [2:0]  state_q, state_d;
  logic        drop_q, drop_d;
  logic [15:0] offset_q, addr_q, lsmp_q, rsmp_q;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] div_q;
  logic [15:0] left_q, right_q;
  logic        strobe_q, underrun_q;

  logic        wr_base, wr_len, wr_ctrl, en_rise, dis_wr;
  logic [15:0] len_fix, off_inc, off_nxt, half_idx, end_idx;
  logic        accept, keep, push, pop, tick, flush;
  logic        fifo_full, fifo_empty;

  assign wr_base = reg_wr && (reg_addr == 2'd0);
  assign wr_len  = reg_wr && (reg_addr == 2'd1);
  assign wr_ctrl = reg_wr && (reg_addr == 2'd2);
  assign en_rise = wr_ctrl && reg_data[0] && !en_q;
  assign dis_wr  = wr_ctrl && !reg_data[0];
  assign len_fix = (reg_data < 16'd4) ? 16'd4 : {reg_data[15:1], 1'b0};

  assign au_rvalid  = (state_q == S_REQ_L) || (state_q == S_REQ_R);
  assign accept     = au_rvalid && au_rready;
  assign keep       = accept && !drop_q;
  assign off_inc    = offset_q + 16'd1;
  assign off_nxt    = (off_inc == cur_len_q) ? 16'd0 : off_inc;
  assign half_idx   = (cur_len_q >> 1) - 16'd1;
  assign end_idx    = cur_len_q - 16'd1;

  assign fifo_full  = (cnt_q == DEPTH);
  assign fifo_empty = (cnt_q == '0);
  assign tick       = en_q && (div_q == DIV_LAST);
  assign pop        = tick && !fifo_empty;
  assign push       = (state_q == S_PUSH) && !drop_q;
  assign flush      = en_rise || (!en_q && state_q == S_IDLE);

  assign au_memory_address = addr_q;
  assign au_left   = left_q;
  assign au_right  = right_q;
  assign au_strobe = strobe_q;
  assign underrun  = underrun_q;
  assign half_irq  = keep && (offset_q == half_idx);
  assign end_irq   = keep && (offset_q == end_idx);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en_q && !dis_wr && !fifo_full) state_d = S_REQ_L;
      S_REQ_L: if (accept) state_d = drop_q ? S_IDLE : S_GAP_L;
      S_GAP_L: state_d = drop_q ? S_IDLE : S_REQ_R;
      S_REQ_R: if (accept) state_d = drop_q ? S_IDLE : S_PUSH;
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // a disabled in-flight word is still completed, then thrown away
    drop_d = (drop_q || dis_wr) && (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      base_q     <= '0;
      len_q      <= 16'd4;
      cur_base_q <= '0;
      cur_len_q  <= 16'd4;
      en_q       <= 1'b0;
    end else begin
      if (wr_base) base_q <= reg_data;
      if (wr_len)  len_q  <= len_fix;
      if (wr_ctrl) en_q   <= reg_data[0];
      if (en_rise) begin
        cur_base_q <= base_q;
        cur_len_q  <= len_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q  <= S_IDLE;
      drop_q   <= 1'b0;
      offset_q <= '0;
      addr_q   <= '0;
      lsmp_q   <= '0;
      rsmp_q   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (en_rise)   offset_q <= '0;
      else if (keep) offset_q <= off_nxt;
      if (state_d != state_q &&
          (state_d == S_REQ_L || state_d == S_REQ_R))
        addr_q <= cur_base_q + offset_q;
      if (keep && state_q == S_REQ_L) lsmp_q <= au_memory_data;
      if (keep && state_q == S_REQ_R) rsmp_q <= au_memory_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= {lsmp_q, rsmp_q};
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      div_q      <= '0;
      left_q     <= '0;
      right_q    <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (!en_q || tick) div_q <= '0;
      else               div_q <= div_q + 1'b1;
      strobe_q <= pop;
      if (pop) begin
        left_q  <= mem_q[rptr_q][31:16];
        right_q <= mem_q[rptr_q][15:0];
      end
      if (wr_ctrl)                   underrun_q <= 1'b0;
      else if (tick && fifo_empty)   underrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_dma.sv
// tb_audio_dma: table of ring configurations plus hand-built
// underrun, disable-in-flight and mid-request reset sequences.
module tb_audio_dma;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [15:0] reg_data = '0;
  logic        reg_wr = 1'b0;
  logic [15:0] au_memory_address;
  logic [15:0] au_memory_data = '0;
  logic        au_rvalid;
  logic        au_rready = 1'b0;
  logic [15:0] au_left, au_right;
  logic        au_strobe, half_irq, end_irq, underrun;

  audio_dma #(
    .CLOCK_FREQ(10000000),
    .SAMPLE_RATE(25000),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK),
    .RSTb(RSTb),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .reg_wr(reg_wr),
    .au_memory_address(au_memory_address),
    .au_memory_data(au_memory_data),
    .au_rvalid(au_rvalid),
    .au_rready(au_rready),
    .au_left(au_left),
    .au_right(au_right),
    .au_strobe(au_strobe),
    .half_irq(half_irq),
    .end_irq(end_irq),
    .underrun(underrun)
  );

  always #50 CLK = ~CLK;

  typedef struct {
    logic [15:0] addr;
    logic        half;
    logic        endi;
  } acc_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] len_w;
    int          exp_len;
  } cfg_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  bit stall = 0;
  bit mon_on = 0;
  int acc_n, str_n, s1_cyc, s2_cyc, en_cyc;
  acc_t exp_acc[$];
  logic [31:0] exp_pair[$];
  cfg_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge CLK);
    reg_addr = a;
    reg_data = d;
    reg_wr   = 1'b1;
    @(negedge CLK);
    reg_wr   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load(input logic [15:0] base, input int l);
    acc_t e;
    logic [15:0] a, b;
    exp_acc.delete();
    exp_pair.delete();
    for (int i = 0; i < 64; i++) begin
      e.addr = base + 16'(i % l);
      e.half = ((i % l) == (l / 2 - 1));
      e.endi = ((i % l) == (l - 1));
      exp_acc.push_back(e);
    end
    for (int k = 0; k < 24; k++) begin
      a = base + 16'((2 * k) % l);
      b = base + 16'((2 * k + 1) % l);
      exp_pair.push_back({a, b});
    end
    acc_n = 0;
    str_n = 0;
    s1_cyc = 0;
    s2_cyc = 0;
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // arbiter model: returns data equal to address after lat wait cycles
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RSTb) begin
        au_rready = 1'b0;
        wcnt = 0;
      end else if (au_rvalid && !au_rready) begin
        if (!stall && wcnt >= lat) begin
          au_rready = 1'b1;
          au_memory_data = au_memory_address;
        end else begin
          wcnt++;
        end
      end else begin
        au_rready = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial forever begin
    acc_t e;
    logic [31:0] p;
    @(negedge CLK);
    if (mon_on && RSTb) begin
      if (au_rvalid && au_rready) begin
        acc_n++;
        chk("acc_queue", 32'(exp_acc.size() != 0), 1);
        if (exp_acc.size() != 0) begin
          e = exp_acc.pop_front();
          chk("acc_addr", au_memory_address, e.addr);
          chk("acc_irq", {half_irq, end_irq}, {e.half, e.endi});
        end
      end else if (half_irq || end_irq) begin
        chk("irq_stray", {half_irq, end_irq}, 0);
      end
      if (au_strobe) begin
        str_n++;
        if (str_n == 1) s1_cyc = cyc;
        if (str_n == 2) s2_cyc = cyc;
        chk("pair_queue", 32'(exp_pair.size() != 0), 1);
        if (exp_pair.size() != 0) begin
          p = exp_pair.pop_front();
          chk("pair_lr", {au_left, au_right}, p);
        end
      end
    end
  end

  initial begin
    bit ok, irq, got;
    tbl[0] = '{16'h4000, 16'd8, 8};
    tbl[1] = '{16'h1234, 16'd5, 4};
    tbl[2] = '{16'hFFFE, 16'd4, 4};
    tbl[3] = '{16'h0100, 16'd2, 4};
    tbl[4] = '{16'h2000, 16'd7, 6};

    idle(3);
    chk("rst_ctl", {au_rvalid, au_strobe, half_irq, end_irq, underrun}, 0);
    chk("rst_addr", au_memory_address, 0);
    chk("rst_lr", {au_left, au_right}, 0);
    RSTb = 1'b1;
    idle(2);

    for (int t = 0; t < 5; t++) begin
      wr(2'd0, tbl[t].base);
      wr(2'd1, tbl[t].len_w);
      load(tbl[t].base, tbl[t].exp_len);
      mon_on = 1;
      wr(2'd2, 16'd1);
      en_cyc = cyc;
      while (cyc < en_cyc + 2100) @(negedge CLK);
      chk("case_strobes", str_n, 5);
      chk("case_words", acc_n, 18);
      chk("first_strobe_dly", s1_cyc - en_cyc, 400);
      chk("strobe_period", s2_cyc - s1_cyc, 400);
      chk("case_underrun", underrun, 0);
      mon_on = 0;
      wr(2'd2, 16'd0);
      idle(20);
    end

    // FIFO drains while the arbiter is stalled
    wr(2'd0, 16'h4000);
    wr(2'd1, 16'd8);
    load(16'h4000, 8);
    mon_on = 1;
    wr(2'd2, 16'd1);
    en_cyc = cyc;
    while (!au_strobe && cyc < en_cyc + 600) @(negedge CLK);
    chk("ur_first_strobe", au_strobe, 1);
    stall = 1;
    while (cyc < en_cyc + 2450) @(negedge CLK);
    chk("ur_flag", underrun, 1);
    chk("ur_hold_lr", {au_left, au_right}, 32'h40064007);
    chk("ur_strobes", str_n, 4);
    chk("ur_pending", {15'd0, au_rvalid, au_memory_address}, 32'h14000);
    wr(2'd2, 16'd1);
    chk("ur_clear", underrun, 0);
    mon_on = 0;
    stall = 0;
    wr(2'd2, 16'd0);
    idle(20);

    // disable while the right word is in flight
    lat = 5;
    wr(2'd0, 16'h4000);
    wr(2'd1, 16'd8);
    wr(2'd2, 16'd1);
    en_cyc = cyc;
    while (!(au_rvalid && au_memory_address == 16'h4003) &&
           cyc < en_cyc + 500) @(negedge CLK);
    chk("dis_reach_r", {15'd0, au_rvalid, au_memory_address}, 32'h14003);
    wr(2'd2, 16'd0);
    ok = 1;
    irq = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (half_irq || end_irq) irq = 1;
      if (au_rvalid && au_rready) begin
        got = 1;
        break;
      end
      if (!au_rvalid) ok = 0;
      @(negedge CLK);
    end
    chk("dis_accept", got, 1);
    chk("dis_hold", ok, 1);
    @(negedge CLK);
    chk("dis_drop", au_rvalid, 0);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (half_irq || end_irq) irq = 1;
      if (au_rvalid) ok = 0;
      @(negedge CLK);
    end
    chk("dis_no_irq", irq, 0);
    chk("dis_quiet", ok, 1);
    lat = 1;
    wr(2'd0, 16'h5000);
    load(16'h5000, 8);
    mon_on = 1;
    wr(2'd2, 16'd1);
    en_cyc = cyc;
    while (cyc < en_cyc + 450) @(negedge CLK);
    chk("reen_strobes", str_n, 1);
    mon_on = 0;
    wr(2'd2, 16'd0);
    idle(20);

    // asynchronous reset in the middle of a left-word request
    wr(2'd0, 16'h4000);
    wr(2'd1, 16'd8);
    wr(2'd2, 16'd1);
    en_cyc = cyc;
    while (!au_strobe && cyc < en_cyc + 600) @(negedge CLK);
    chk("pre_rst_left", au_left, 16'h4000);
    lat = 5;
    en_cyc = cyc;
    while (!au_rvalid && cyc < en_cyc + 50) @(negedge CLK);
    chk("pre_rst_req", {15'd0, au_rvalid, au_memory_address}, 32'h14000);
    #2;
    RSTb = 1'b0;
    #1;
    chk("arst_ctl", {au_rvalid, au_strobe, half_irq, end_irq, underrun}, 0);
    chk("arst_addr", au_memory_address, 0);
    chk("arst_lr", {au_left, au_right}, 0);
    @(negedge CLK);
    RSTb = 1'b1;
    ok = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (au_rvalid) ok = 0;
    end
    chk("post_rst_quiet", ok, 1);
    lat = 1;
    wr(2'd0, 16'h3000);
    wr(2'd1, 16'd4);
    wr(2'd2, 16'd1);
    en_cyc = cyc;
    while (!au_rvalid && cyc < en_cyc + 20) @(negedge CLK);
    chk("post_rst_addr", {15'd0, au_rvalid, au_memory_address}, 32'h13000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
